// File: rtl/enemy_laser_if.sv
// rtl/enemy_laser_if.sv - fire request handshake between invader formation and enemy laser
interface enemy_laser_if;
    logic       fire_i;
    logic [9:0] fire_x_i;
    logic [9:0] fire_y_i;
    logic       fire_ack_o;

    modport master (
        output fire_i,
        output fire_x_i,
        output fire_y_i,
        input  fire_ack_o
    );

    modport slave (
        input  fire_i,
        input  fire_x_i,
        input  fire_y_i,
        output fire_ack_o
    );
endinterface

// File: rtl/enemy_laser.sv
// rtl/enemy_laser.sv - single enemy projectile: fire acceptance, fall, player collision, cooldown
module enemy_laser #(
    parameter int speed_p         = 4,
    parameter int laser_w_p       = 3,
    parameter int laser_h_p       = 10,
    parameter int player_top_p    = 440,
    parameter int player_bottom_p = 460,
    parameter int bottom_border_p = 479,
    parameter int cooldown_p      = 30
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        frame_i,
    input  logic        pause_i,
    enemy_laser_if.slave fire_if,
    input  logic [9:0]  player_left_i,
    input  logic [9:0]  player_right_i,
    input  logic        player_alive_i,
    output logic        hit_o,
    output logic        laser_active_o,
    output logic [9:0]  laser_x_o,
    output logic [9:0]  laser_y_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        FLYING   = 3'b010,
        COOLDOWN = 3'b100
    } state_t;

    localparam int cnt_w = (cooldown_p > 0) ? $clog2(cooldown_p + 1) : 1;

    localparam logic [10:0] w_m1_c   = 11'(laser_w_p - 1);
    localparam logic [10:0] h_m1_c   = 11'(laser_h_p - 1);
    localparam logic [10:0] top_c    = 11'(player_top_p);
    localparam logic [10:0] bot_c    = 11'(player_bottom_p);
    localparam logic [10:0] border_c = 11'(bottom_border_p);
    localparam logic [10:0] speed_c  = 11'(speed_p);
    localparam logic [cnt_w-1:0] cool_c = cnt_w'(cooldown_p);
    localparam logic [cnt_w-1:0] one_c  = cnt_w'(1);

    state_t             state_q, state_n;
    logic [9:0]         x_q, x_n, y_q, y_n;
    logic [cnt_w-1:0]   cnt_q, cnt_n;
    logic               active_q, active_n;
    logic               ack, hit, tick, overlap;
    logic [10:0]        x_ext, y_ext, y_step;

    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};
    assign y_step = y_ext + speed_c;
    assign tick   = frame_i & ~pause_i;

    // Collision window uses the position the laser held during the frame just ended.
    assign overlap = (x_ext <= {1'b0, player_right_i}) &&
                     (x_ext + w_m1_c >= {1'b0, player_left_i}) &&
                     (y_ext + h_m1_c >= top_c) &&
                     (y_ext <= bot_c) &&
                     player_alive_i;

    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        cnt_n   = cnt_q;
        ack     = 1'b0;
        hit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire_if.fire_i && !pause_i) begin
                    ack     = 1'b1;
                    x_n     = fire_if.fire_x_i;
                    y_n     = fire_if.fire_y_i;
                    state_n = FLYING;
                end
            end
            FLYING: begin
                if (tick) begin
                    if (overlap) begin
                        hit     = 1'b1;
                        state_n = COOLDOWN;
                        cnt_n   = cool_c;
                    end else if (y_step + h_m1_c > border_c) begin
                        state_n = COOLDOWN;
                        cnt_n   = cool_c;
                    end else begin
                        y_n = y_step[9:0];
                    end
                end
            end
            COOLDOWN: begin
                // A zero count on entry only happens when cooldown_p is 0.
                if (!pause_i) begin
                    if (cnt_q == '0) begin
                        state_n = IDLE;
                    end else if (frame_i) begin
                        cnt_n = cnt_q - one_c;
                        if (cnt_q == one_c) state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (clear_i) begin
            state_n = IDLE;
            x_n     = '0;
            y_n     = '0;
            cnt_n   = '0;
            ack     = 1'b0;
            hit     = 1'b0;
        end
        active_n = (state_n == FLYING);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            x_q      <= x_n;
            y_q      <= y_n;
            cnt_q    <= cnt_n;
            active_q <= active_n;
        end
    end

    assign fire_if.fire_ack_o = ack & ~reset_i;
    assign hit_o              = hit & ~reset_i;
    assign laser_active_o     = active_q;
    assign laser_x_o          = x_q;
    assign laser_y_o          = y_q;
    assign state_o            = state_q;

endmodule

// File: doc/enemy_laser.md
Name: enemy_laser

Overview:
- Single enemy projectile engine. It is the producing end of the player's hit interface.
- Accepts fire requests from the invader formation and drops a laser down the screen once per frame.
- Checks overlap against the player ship span (pos_left/pos_right from the player block) and drives the player's hit input.
- Outputs laser position and an active flag to the pixel/display logic.

Parameters:
speed_p, 4, pixels moved down per frame
laser_w_p, 3, laser width in pixels (x .. x+w-1)
laser_h_p, 10, laser height in pixels (y .. y+h-1)
player_top_p, 440, top row of player ship
player_bottom_p, 460, bottom row of player ship
bottom_border_p, 479, last visible row
cooldown_p, 30, frames between end of one laser and next fire acceptance

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous active-high reset
clear_i  input  1  synchronous flush (new game/resume); returns to IDLE
frame_i  input  1  one-cycle frame tick
pause_i  input  1  freeze: no motion, collision, cooldown or fire acceptance
fire_i  input  1  fire request from formation
fire_x_i  input  10  spawn column (left edge)
fire_y_i  input  10  spawn row (top edge)
player_left_i  input  10  player left x, inclusive
player_right_i  input  10  player right x, inclusive
player_alive_i  input  1  collisions only counted when high
fire_ack_o  output  1  fire accepted this cycle
hit_o  output  1  player hit; one cycle, coincident with frame_i
laser_active_o  output  1  laser on screen
laser_x_o  output  10  laser left x
laser_y_o  output  10  laser top y
state_o  output  3  one-hot present state (debug)

Behaviour:
- States, one-hot: IDLE=3'b001, FLYING=3'b010, COOLDOWN=3'b100. Any other encoding recovers to IDLE on the next cycle.
- Reset (async, any time): state IDLE; laser_x/laser_y=0; laser_active_o=0; cooldown count=0.
- Reset combinational outputs: fire_ack_o=0, hit_o=0, state_o=3'b001.
- clear_i: synchronous return to IDLE, same register values as reset. Has priority over every other input except reset_i.
- IDLE:
  - fire_i & ~pause_i: fire_ack_o=1 combinationally; latch x=fire_x_i, y=fire_y_i; next state FLYING.
  - laser_active_o goes high the cycle after acceptance.
  - A frame_i in the acceptance cycle does not move the laser.
- FLYING (laser_active_o=1). Evaluated only on cycles with frame_i & ~pause_i, using current registered x,y:
  - overlap = (x <= player_right_i) & (x+laser_w_p-1 >= player_left_i) & (y+laser_h_p-1 >= player_top_p) & (y <= player_bottom_p) & player_alive_i.
  - Comparisons are inclusive and computed 11 bits wide.
  - If overlap: hit_o=1 combinationally that cycle; next state COOLDOWN; y not advanced.
  - Else y_next = y+speed_p (11-bit). If y_next+laser_h_p-1 > bottom_border_p, the shot misses: next state COOLDOWN.
  - Otherwise y <= y_next[9:0].
  - Hit has priority over bottom miss.
  - fire_i is ignored and fire_ack_o=0.
- COOLDOWN:
  - laser_active_o=0; x,y hold their last values.
  - Count loads cooldown_p on entry.
  - Each frame_i & ~pause_i decrements; the frame that takes count to 0 moves to IDLE.
  - cooldown_p=0: go to IDLE on the cycle after entry.
  - fire_i is ignored.
- pause_i high: state, position and count frozen; hit_o=0; fire_ack_o=0.
- hit_o is never asserted outside FLYING or without frame_i. The player samples hit together with frame_i for its lives decrement.
- laser_x_o, laser_y_o, laser_active_o are registered; state_o is the present-state register.

Test Plan:
- Reset, fire_x_i=260, fire_y_i=100, player 249..289, alive:
  - launch → y steps 100,104,…
  - hit_o pulses on the 84th frame after launch (y=432), with frame_i.
  - Then COOLDOWN, laser_active_o=0, no further hit.
- Fire x=100 (no overlap), y=100 → no hit_o. On the 93rd frame (y=468, y_next=472) go to COOLDOWN. After 30 frames state_o=3'b001.
- Boundary x: player_right_i=289, fire x=290 → no hit. fire x=287 → hit. player_alive_i=0 with x=260 → no hit, exits at bottom.
- fire_i held during FLYING and COOLDOWN → fire_ack_o=0. The first fire after 30 cooldown frames → fire_ack_o=1 for one cycle.
- Asserting pause_i for 50 frames mid-flight (y=200) → y stays 200, no hit, count frozen. Release → resumes at 204.
- Async reset_i, and separately clear_i, mid-flight (y=300) → IDLE, laser_active_o=0, x=y=0.
  - reset_i clears immediately without a clock edge.
  - clear_i clears on the next edge.
